// File: rtl/mod_mul_p_seq_pkg.sv
// Shared SM2 field constants and the multiplier state encoding.
//   SM2_P    : field modulus, 256 bits
//   SM2_P257 : modulus zero-extended to 257 bits, for carry-aware compares
//   state_t  : IDLE / CALC / DONE
package mod_mul_p_seq_pkg;

    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    localparam logic [256:0] SM2_P257 = {1'b0, SM2_P};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_mul_p_seq_if.sv
// Request/result bundle of the sequential modular multiplier.
//   master : requester side (drives start/a/b, receives c/busy/done/err)
//   slave  : multiplier side
interface mod_mul_if;

    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] c;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, a, b,
        input  c, busy, done, err
    );

    modport slave (
        input  start, a, b,
        output c, busy, done, err
    );

endinterface

// File: rtl/mod_mul_p_seq_add.sv
// Combinational quick modular adder: sum = (x + y) mod P.
// Both operands must already be < P, so a single conditional subtract
// is enough to bring the 257-bit sum back into range.
//   x, y : addends (< P)
//   sum  : result (< P)
module mod_add_p_comb_quick
    import mod_mul_p_seq_pkg::*;
#(
    parameter logic [255:0] P = SM2_P
) (
    input  logic [255:0] x,
    input  logic [255:0] y,
    output logic [255:0] sum
);

    localparam logic [256:0] P_EXT = {1'b0, P};

    logic [256:0] sum_ext;
    logic [255:0] sum_red;

    // The reduced value always fits in 256 bits, so the subtraction can
    // drop the carry bit and rely on modulo-2^256 wrap.
    always_comb begin
        sum_ext = {1'b0, x} + {1'b0, y};
        sum_red = sum_ext[255:0] - P;
        sum     = (sum_ext >= P_EXT) ? sum_red : sum_ext[255:0];
    end

endmodule

// File: rtl/mod_mul_p_seq.sv
// Sequential SM2 field multiplier, c = a*b mod P.
// MSB-first interleaved double-and-add, one multiplier bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus.start  : request, sampled only in IDLE together with a, b
//   bus.c      : result, held from done until the next accepted start
//   bus.busy   : high in CALC and DONE
//   bus.done   : one-cycle pulse, c and err valid
//   bus.err    : operand out of range (a >= P or b >= P)
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// CALC  | 256 double-and-add steps, bit cnt of b_r
// DONE  | done pulse, then back to IDLE
module mod_mul_p_seq
    import mod_mul_p_seq_pkg::*;
#(
    parameter int           WIDTH = 256,
    parameter logic [255:0] P     = SM2_P
) (
    input  logic         clk,
    input  logic         rst_n,
    mod_mul_if.slave     bus
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [7:0]       cnt;

    logic [WIDTH-1:0] dbl;
    logic [WIDTH-1:0] dbl_add;
    logic [WIDTH-1:0] acc_nxt;
    logic             range_bad;

    mod_add_p_comb_quick #(.P(P)) u_add_dbl (
        .x   (acc),
        .y   (acc),
        .sum (dbl)
    );

    mod_add_p_comb_quick #(.P(P)) u_add_acc (
        .x   (dbl),
        .y   (a_r),
        .sum (dbl_add)
    );

    always_comb begin
        acc_nxt   = b_r[cnt] ? dbl_add : dbl;
        range_bad = (bus.a >= P) || (bus.b >= P);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            cnt      <= 8'd255;
            bus.c    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (range_bad) begin
                            // Skip the computation entirely; report at once.
                            bus.err  <= 1'b1;
                            bus.c    <= '0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            a_r     <= bus.a;
                            b_r     <= bus.b;
                            acc     <= '0;
                            cnt     <= 8'd255;
                            bus.err <= 1'b0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (cnt == 8'd0) begin
                        bus.c    <= acc_nxt;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_p_seq.sv
// Self-checking bench for mod_mul_p_seq: directed cases plus randomized
// back-to-back operations against a wide-arithmetic golden model.
module tb_mod_mul_p_seq;

    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] R2_256 =
        256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;

    typedef struct {
        logic         err;
        logic [255:0] c;
    } exp_t;

    logic clk;
    logic rst_n;
    mod_mul_if bus ();

    mod_mul_p_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    exp_t         exp_q[$];
    logic [255:0] held_c   = '0;
    logic         held_err = 1'b0;
    bit           hold_ok  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] golden(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] prod;
        prod = {256'd0, x} * {256'd0, y};
        prod = prod % {256'd0, P};
        return prod[255:0];
    endfunction

    function automatic logic [255:0] rand_word256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] rand_op();
        logic [255:0] v;
        case ($urandom_range(0, 7))
            0:       v = P - 256'd1 - 256'($urandom_range(0, 15));
            1:       v = 256'($urandom_range(0, 15));
            default: begin
                v = rand_word256();
                while (v >= P) v = rand_word256();
            end
        endcase
        return v;
    endfunction

    // Compare process: checks every done pulse against the model queue and
    // checks that c/err hold while the block is idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_c   = '0;
            held_err = 1'b0;
            hold_ok  = 1'b1;
        end else if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_c", bus.c, e.c);
                chk("done_err", {255'd0, bus.err}, {255'd0, e.err});
                chk("done_busy", {255'd0, bus.busy}, 256'd1);
            end
            held_c   = bus.c;
            held_err = bus.err;
            hold_ok  = 1'b1;
        end else if (bus.busy === 1'b0 && hold_ok) begin
            chk("hold_c", bus.c, held_c);
            chk("hold_err", {255'd0, bus.err}, {255'd0, held_err});
        end
    end

    // Present operands and start, accept at the next rising edge, then
    // scramble the operands (they may change freely after acceptance).
    task automatic accept(input logic [255:0] x, input logic [255:0] y);
        exp_t e;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        e.err = (x >= P) || (y >= P);
        e.c   = e.err ? 256'd0 : golden(x, y);
        exp_q.push_back(e);
        #1;
        bus.start = 1'b0;
        bus.a     = rand_word256();
        bus.b     = rand_word256();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) break;
            if (n >= 400) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
                break;
            end
        end
    endtask

    initial begin
        int n;
        int dones;
        logic [255:0] x, y;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_c", bus.c, 256'd0);
        chk("rst_busy", {255'd0, bus.busy}, 256'd0);
        chk("rst_done", {255'd0, bus.done}, 256'd0);
        chk("rst_err", {255'd0, bus.err}, 256'd0);
        rst_n = 1'b1;

        // model pinned against hand-computed values
        chk("model_3x5", golden(256'd3, 256'd5), 256'd15);
        chk("model_pm1_sq", golden(P - 256'd1, P - 256'd1), 256'd1);
        chk("model_2_pow255", golden(256'd2, 256'd1 << 255), R2_256);

        @(negedge clk);
        accept(256'd3, 256'd5);
        wait_done(n);
        chk("lat_small", 256'(n), 256'd257);
        chk("c_small", bus.c, 256'd15);
        chk("err_small", {255'd0, bus.err}, 256'd0);

        @(negedge clk);
        accept(P - 256'd1, P - 256'd1);
        wait_done(n);
        chk("c_pm1_sq", bus.c, 256'd1);

        @(negedge clk);
        accept(P - 256'd1, 256'd2);
        wait_done(n);
        chk("c_pm1_x2", bus.c, P - 256'd2);

        @(negedge clk);
        accept(P, 256'd1);
        wait_done(n);
        chk("lat_err", 256'(n), 256'd1);
        chk("err_flag", {255'd0, bus.err}, 256'd1);
        chk("err_c", bus.c, 256'd0);
        repeat (3) @(negedge clk);

        accept(256'd0, P - 256'd1);
        wait_done(n);
        chk("c_zero", bus.c, 256'd0);
        chk("err_zero", {255'd0, bus.err}, 256'd0);

        // start pulsed mid-calculation must be ignored
        @(negedge clk);
        accept(256'd7, 256'd9);
        repeat (99) @(negedge clk);
        bus.a     = 256'd1;
        bus.b     = 256'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        chk("lat_ignored", 256'(n), 256'd157);
        chk("c_ignored", bus.c, 256'd63);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("single_done", 256'(dones), 256'd0);
        chk("c_held", bus.c, 256'd63);

        // reset in the middle of an operation
        accept(256'd11, 256'd13);
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_c", bus.c, 256'd0);
        chk("mid_rst_busy", {255'd0, bus.busy}, 256'd0);
        chk("mid_rst_done", {255'd0, bus.done}, 256'd0);
        chk("mid_rst_err", {255'd0, bus.err}, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("no_done_after_rst", 256'(dones), 256'd0);

        accept(256'd2, 256'd1 << 255);
        wait_done(n);
        chk("c_2_pow256", bus.c, R2_256);

        // back-to-back random operations: start re-pulsed in the done cycle
        // with junk operands (ignored) and held into the next cycle (accepted)
        for (int k = 0; k < 200; k++) begin
            x = rand_op();
            y = rand_op();
            bus.a     = rand_word256();
            bus.b     = rand_word256();
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            accept(x, y);
            wait_done(n);
            if (n != 257) chk("lat_rand", 256'(n), 256'd257);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
